// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bit/byte engines: FSM state encoding and default word width.
package i2c_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_LOW  = 3'd1,
      WAIT_HIGH = 3'd2,
      HIGH      = 3'd3,
      STRETCH   = 3'd4
   } i2c_state_t;

endpackage

// File: rtl/i2c_edge_det.sv
// SCL/SDA history registers plus SCL edge and START/STOP condition detection.
// Shared between the I2C read and write engines.
module i2c_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);

   logic sclLast_q;
   logic sdaLast_q;

   // Both lines idle high on an I2C bus, so the history resets to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclLast_q <= 1'b1;
         sdaLast_q <= 1'b1;
      end else begin
         sclLast_q <= scl_i;
         sdaLast_q <= sda_i;
      end
   end

   assign scl_rise_o = en_i & ~sclLast_q &  scl_i;
   assign scl_fall_o = en_i &  sclLast_q & ~scl_i;
   assign start_o    = en_i & scl_i &  sdaLast_q & ~sda_i;
   assign stop_o     = en_i & scl_i & ~sdaLast_q &  sda_i;

endmodule

// File: rtl/i2c_read.sv
// I2C receive engine: samples SDA on SCL rise, commits each bit on SCL fall, MSB first.
// Optional SCL stretching after each word is enabled by defining I2C_READ_STRETCH_EN.
module i2c_read
   import i2c_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_en,
   input  logic                  is_byte,
   input  logic                  rd_ack,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  rd_finish,
   output logic                  get_start,
   output logic                  get_stop,
   output logic                  bus_err,
   input  logic                  scl_i,
   input  logic                  sda_i,
   output logic                  sda_o,
   output logic                  scl_o
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   i2c_state_t            state_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [DATA_WIDTH-1:0] shift_d;
   logic [DATA_WIDTH-1:0] dataOut_q;
   logic [DATA_WIDTH-1:0] wordOut_d;
   logic [CW-1:0]         bitCnt_q;
   logic                  sampleBit_q;
   logic                  rdFinish_q;
   logic                  busErr_q;
   logic                  wordDone_d;
   logic                  sclRise;
   logic                  sclFall;
   logic                  startDet;
   logic                  stopDet;

   i2c_edge_det u_edge_det (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (rd_en),
      .scl_i      (scl_i),
      .sda_i      (sda_i),
      .scl_rise_o (sclRise),
      .scl_fall_o (sclFall),
      .start_o    (startDet),
      .stop_o     (stopDet)
   );

   assign shift_d    = {shift_q[DATA_WIDTH-2:0], sampleBit_q};
   assign wordDone_d = is_byte ? (bitCnt_q == LAST_BIT) : 1'b1;
   assign wordOut_d  = is_byte ? shift_d : {{(DATA_WIDTH-1){1'b0}}, sampleBit_q};

`ifdef I2C_READ_STRETCH_EN
   logic sclO_q;
`else
   logic unusedAck;
   assign unusedAck = rd_ack;
`endif

   // Bit engine. A START/STOP while SCL is high aborts the word; it is only an error
   // if some bits of the word had already been committed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         dataOut_q   <= '0;
         bitCnt_q    <= '0;
         sampleBit_q <= 1'b0;
         rdFinish_q  <= 1'b0;
         busErr_q    <= 1'b0;
`ifdef I2C_READ_STRETCH_EN
         sclO_q      <= 1'b1;
`endif
      end else begin
         rdFinish_q <= 1'b0;
         if (!rd_en) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bitCnt_q <= '0;
            busErr_q <= 1'b0;
`ifdef I2C_READ_STRETCH_EN
            sclO_q   <= 1'b1;
`endif
         end else begin
            case (state_q)
               IDLE: begin
                  state_q <= scl_i ? WAIT_LOW : WAIT_HIGH;
               end
               WAIT_LOW: begin
                  if (!scl_i) state_q <= WAIT_HIGH;
               end
               WAIT_HIGH: begin
                  if (sclRise) begin
                     sampleBit_q <= sda_i;
                     state_q     <= HIGH;
                  end
               end
               HIGH: begin
                  if (startDet || stopDet) begin
                     if (bitCnt_q != '0) busErr_q <= 1'b1;
                     bitCnt_q <= '0;
                     shift_q  <= '0;
                     state_q  <= WAIT_LOW;
                  end else if (sclFall) begin
                     if (wordDone_d) begin
                        dataOut_q  <= wordOut_d;
                        rdFinish_q <= 1'b1;
                        bitCnt_q   <= '0;
                        shift_q    <= '0;
`ifdef I2C_READ_STRETCH_EN
                        sclO_q     <= 1'b0;
                        state_q    <= STRETCH;
`else
                        state_q    <= WAIT_HIGH;
`endif
                     end else begin
                        shift_q  <= shift_d;
                        bitCnt_q <= bitCnt_q + 1'b1;
                        state_q  <= WAIT_HIGH;
                     end
                  end
               end
`ifdef I2C_READ_STRETCH_EN
               STRETCH: begin
                  if (rd_ack) begin
                     sclO_q  <= 1'b1;
                     state_q <= WAIT_HIGH;
                  end
               end
`endif
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign data_o    = dataOut_q;
   assign rd_finish = rdFinish_q;
   assign bus_err   = busErr_q;
   assign get_start = startDet;
   assign get_stop  = stopDet;
   assign sda_o     = 1'b1;

   // Dropping rd_en releases a stretched SCL without waiting for the register to clear.
`ifdef I2C_READ_STRETCH_EN
   assign scl_o = sclO_q | ~rd_en;
`else
   assign scl_o = 1'b1;
`endif

endmodule
